// File: rtl/divider_if.sv
// Handshake and operand/result bundle for the radix-2 restoring divider.
// The remainder signal exists only when DIVIDER_REMAINDER_EN is defined.
interface divider_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             div0;
`ifdef DIVIDER_REMAINDER_EN
  logic [WIDTH-1:0] remainder;
`endif

  modport master (
    output start, dividend, divisor,
`ifdef DIVIDER_REMAINDER_EN
    input  remainder,
`endif
    input  busy, ready, result, div0
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef DIVIDER_REMAINDER_EN
    output remainder,
`endif
    output busy, ready, result, div0
  );
endinterface

// File: rtl/divider.sv
// Unsigned radix-2 restoring divider: fixed WIDTH-cycle latency, IDLE/RUN/DONE FSM.
// Optional remainder output enabled by defining DIVIDER_REMAINDER_EN.
module divider #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] result_q;
  logic             div0_q;
`ifdef DIVIDER_REMAINDER_EN
  logic [WIDTH-1:0] remainder_q;
`endif

  logic             accept;
  logic             last;
  logic [WIDTH+1:0] shifted;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  assign accept = bus.start && (state_q != RUN);
  assign last   = (count_q == CW'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign borrow   = shifted < {2'b00, dvsr_q};
  assign rem_next = (WIDTH+1)'(borrow ? shifted : shifted - {2'b00, dvsr_q});
  assign quo_next = {quo_q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      result_q    <= '0;
      div0_q      <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
      remainder_q <= '0;
`endif
    end else if (accept) begin
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= bus.dividend;
      dvsr_q  <= bus.divisor;
    end else if (state_q == RUN) begin
      rem_q   <= rem_next;
      quo_q   <= quo_next;
      count_q <= last ? '0 : count_q + 1'b1;
      if (last) begin
        // A zero divisor never borrows, so the quotient is all ones and the
        // remainder is the dividend without any special-case datapath.
        result_q    <= quo_next;
        div0_q      <= (dvsr_q == '0);
`ifdef DIVIDER_REMAINDER_EN
        remainder_q <= rem_next[WIDTH-1:0];
`endif
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.ready  = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.div0   = div0_q;
`ifdef DIVIDER_REMAINDER_EN
  assign bus.remainder = remainder_q;
`endif

endmodule
